uart_bus_master: RTL and testbench

- UART-side bus initiator (debug/loader port). It decodes a byte command stream from the existing UART receiver byte interface and issues 32-bit word reads and writes on the data-memory bus.
- It returns responses through the existing UART transmitter byte interface.
- It sits beside the CPU in the top level. The top level muxes its bus onto the data RAM / peripheral path while `active` is high; the CPU is stalled externally.

---
 rtl/uart_bus_master_if.sv | 28 ++
 rtl/uart_bus_master.sv | 159 +++++++++++++++
 tb/tb_uart_bus_master.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_master_if.sv
// UART byte streams and data-memory bus of the UART debug/loader bus master.
// The master modport is the bus master's view; slave is the top level / test environment view.
interface uart_bus_master_if;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        active;
    logic        err_pulse;

    modport master (
        input  rx_valid, rx_byte, tx_busy, tx_done, mem_rdata, mem_ready,
        output tx_start, tx_byte, mem_req, mem_we, mem_addr, mem_wdata, active, err_pulse
    );

    modport slave (
        output rx_valid, rx_byte, tx_busy, tx_done, mem_rdata, mem_ready,
        input  tx_start, tx_byte, mem_req, mem_we, mem_addr, mem_wdata, active, err_pulse
    );
endinterface

// File: rtl/uart_bus_master.sv
// UART command decoder issuing single 32-bit word reads/writes on the data bus.
// 'W' addr[4] data[4] -> write + ACK; 'R' addr[4] -> read + 4 data bytes; anything else -> NAK.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic               clk,
    input  logic               reset,
    uart_bus_master_if.master  bus
);

    localparam logic [7:0]     CMD_W = 8'h57;
    localparam logic [7:0]     CMD_R = 8'h52;
    localparam int unsigned    TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_BUS, S_SEND, S_WAIT_TX
    } state_t;

    state_t         state_q, state_d;
    logic           is_wr_q;
    logic [1:0]     cnt_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    resp_q;
    logic [1:0]     last_q;
    logic [1:0]     idx_q;
    logic [TW-1:0]  tout_q;
    logic           mem_req_q;
    logic           tx_start_q;
    logic [7:0]     tx_byte_q;
    logic           err_q;

    logic in_rx, tout_hit, drop, bus_done, tx_ack, is_cmd;

    always_comb begin
        in_rx    = (state_q == S_ADDR) || (state_q == S_DATA);
        // An arriving byte beats expiry in the same cycle.
        tout_hit = in_rx && !bus.rx_valid && (tout_q == TOUT_MAX);
        drop     = bus.rx_valid &&
                   ((state_q == S_BUS) || (state_q == S_SEND) || (state_q == S_WAIT_TX));
        bus_done = mem_req_q && bus.mem_ready;
        // A done pulse cannot belong to a byte launched this very cycle.
        tx_ack   = bus.tx_done && !tx_start_q;
        is_cmd   = (bus.rx_byte == CMD_W) || (bus.rx_byte == CMD_R);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) state_d = is_cmd ? S_ADDR : S_SEND;
            end
            S_ADDR: begin
                if (tout_hit)                             state_d = S_IDLE;
                else if (bus.rx_valid && cnt_q == 2'd3)   state_d = is_wr_q ? S_DATA : S_BUS;
            end
            S_DATA: begin
                if (tout_hit)                             state_d = S_IDLE;
                else if (bus.rx_valid && cnt_q == 2'd3)   state_d = S_BUS;
            end
            S_BUS: begin
                if (bus_done) state_d = S_SEND;
            end
            S_SEND: begin
                if (!bus.tx_busy) state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_ack) state_d = (idx_q == last_q) ? S_IDLE : S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_wr_q    <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            last_q     <= '0;
            idx_q      <= '0;
            tout_q     <= '0;
            mem_req_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            err_q      <= tout_hit || drop;

            if (in_rx && !bus.rx_valid && !tout_hit) tout_q <= tout_q + 1'b1;
            else                                     tout_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        is_wr_q <= (bus.rx_byte == CMD_W);
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        resp_q  <= {24'h0, NAK_BYTE};
                        last_q  <= '0;
                    end
                end
                S_ADDR: begin
                    if (bus.rx_valid) begin
                        // Word address: the two byte-offset bits are never stored.
                        addr_q[{cnt_q, 3'b000} +: 8] <= (cnt_q == 2'd0) ?
                            {bus.rx_byte[7:2], 2'b00} : bus.rx_byte;
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        wdata_q[{cnt_q, 3'b000} +: 8] <= bus.rx_byte;
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        mem_req_q <= 1'b0;
                        resp_q    <= is_wr_q ? {24'h0, ACK_BYTE} : bus.mem_rdata;
                        last_q    <= is_wr_q ? 2'd0 : 2'd3;
                    end else begin
                        mem_req_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= resp_q[{idx_q, 3'b000} +: 8];
                    end
                end
                S_WAIT_TX: begin
                    if (tx_ack && idx_q != last_q) idx_q <= idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_req_q & is_wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.active    = (state_q != S_IDLE);
    assign bus.err_pulse = err_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized bench for uart_bus_master: transaction-level model of the command protocol,
// bus/transmitter responders, and a negedge monitor checking every bus and tx event.
module tb_uart_bus_master;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_op_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_bus_master_if u_if ();

    uart_bus_master #(.TIMEOUT_CYCLES(100), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // ---------------- reference model ----------------
    bus_op_t      exp_bus[$];
    logic [7:0]   exp_tx[$];
    logic [31:0]  ref_mem[16];
    int           exp_err = 0;
    logic [7:0]   cmd_q[$];

    task automatic init_ref();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic model_cmd();
        logic [31:0] a, d;
        bus_op_t op;
        if ((cmd_q[0] == 8'h57 && cmd_q.size() == 9) || (cmd_q[0] == 8'h52 && cmd_q.size() == 5)) begin
            a = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]} & 32'hFFFF_FFFC;
            if (cmd_q[0] == 8'h57) begin
                d = {cmd_q[8], cmd_q[7], cmd_q[6], cmd_q[5]};
                op.we = 1'b1; op.addr = a; op.wdata = d;
                exp_bus.push_back(op);
                ref_mem[a[5:2]] = d;
                exp_tx.push_back(8'h06);
            end else begin
                op.we = 1'b0; op.addr = a; op.wdata = 32'h0;
                exp_bus.push_back(op);
                d = ref_mem[a[5:2]];
                for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
            end
        end else begin
            exp_tx.push_back(8'h15);
        end
    endtask

    task automatic mk_w(input logic [31:0] a, input logic [31:0] d);
        cmd_q.delete();
        cmd_q.push_back(8'h57);
        for (int i = 0; i < 4; i++) cmd_q.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) cmd_q.push_back(d[8*i +: 8]);
    endtask

    task automatic mk_r(input logic [31:0] a);
        cmd_q.delete();
        cmd_q.push_back(8'h52);
        for (int i = 0; i < 4; i++) cmd_q.push_back(a[8*i +: 8]);
    endtask

    // ---------------- environment: bus slave ----------------
    logic [31:0] bus_mem[16];
    int req_cyc, cur_wait;
    int wait_mode = -1;

    assign u_if.mem_ready = u_if.mem_req &&
                            (req_cyc == ((wait_mode >= 0) ? wait_mode : cur_wait));
    assign u_if.mem_rdata = u_if.mem_ready ? bus_mem[u_if.mem_addr[5:2]] : 32'hBAD0_BAD0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            req_cyc  <= 0;
            cur_wait <= 0;
            for (int i = 0; i < 16; i++) bus_mem[i] <= init_word(i);
        end else if (u_if.mem_ready) begin
            req_cyc  <= 0;
            cur_wait <= int'($urandom_range(0, 3));
            if (u_if.mem_we) bus_mem[u_if.mem_addr[5:2]] <= u_if.mem_wdata;
        end else if (u_if.mem_req) begin
            req_cyc <= req_cyc + 1;
        end
    end

    // ---------------- environment: transmitter ----------------
    int tx_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            u_if.tx_busy <= 1'b0;
            u_if.tx_done <= 1'b0;
            tx_cnt       <= 0;
        end else begin
            u_if.tx_done <= 1'b0;
            if (u_if.tx_busy) begin
                if (tx_cnt == 0) begin
                    u_if.tx_busy <= 1'b0;
                    u_if.tx_done <= 1'b1;
                end else begin
                    tx_cnt <= tx_cnt - 1;
                end
            end else if (u_if.tx_start) begin
                u_if.tx_busy <= 1'b1;
                tx_cnt       <= int'($urandom_range(1, 5));
            end
        end
    end

    // ---------------- monitor / compare ----------------
    logic        prev_req, prev_err, tx_inflight;
    logic [64:0] hold_bus;
    logic [7:0]  tx_hold;
    logic [7:0]  tx_log[$];
    logic [31:0] last_addr, last_wdata;
    logic        last_we;
    int          req_len, last_req_len, n_req, err_seen;

    initial begin
        prev_req = 0; prev_err = 0; tx_inflight = 0; n_req = 0; err_seen = 0;
        req_len = 0; last_req_len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 0; prev_err = 0; tx_inflight = 0;
            end else begin
                if (u_if.mem_req && !prev_req) begin
                    bus_op_t op;
                    n_req++;
                    req_len = 1;
                    if (exp_bus.size() == 0) begin
                        chk("bus_unexpected", 32'd1, 32'd0);
                    end else begin
                        op = exp_bus.pop_front();
                        chk("bus_we", {31'h0, u_if.mem_we}, {31'h0, op.we});
                        chk("bus_addr", u_if.mem_addr, op.addr);
                        if (op.we) chk("bus_wdata", u_if.mem_wdata, op.wdata);
                    end
                    hold_bus   = {u_if.mem_we, u_if.mem_addr, u_if.mem_wdata};
                    last_addr  = u_if.mem_addr;
                    last_wdata = u_if.mem_wdata;
                    last_we    = u_if.mem_we;
                end else if (u_if.mem_req) begin
                    req_len++;
                    chk("bus_stable", {31'h0, ({u_if.mem_we, u_if.mem_addr, u_if.mem_wdata} == hold_bus)}, 32'd1);
                end
                if (u_if.mem_ready) last_req_len = req_len;

                if (u_if.tx_start) begin
                    chk("tx_start_busy", {30'h0, u_if.tx_busy, tx_inflight}, 32'd0);
                    if (exp_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                    else chk("tx_byte", {24'h0, u_if.tx_byte}, {24'h0, exp_tx.pop_front()});
                    tx_hold     = u_if.tx_byte;
                    tx_inflight = 1'b1;
                    tx_log.push_back(u_if.tx_byte);
                end else if (tx_inflight) begin
                    chk("tx_stable", {24'h0, u_if.tx_byte}, {24'h0, tx_hold});
                end
                if (u_if.tx_done) tx_inflight = 1'b0;

                if (u_if.err_pulse) begin
                    err_seen++;
                    chk("err_width", {31'h0, prev_err}, 32'd0);
                end
                prev_req = u_if.mem_req;
                prev_err = u_if.err_pulse;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        u_if.rx_valid = 1'b1;
        u_if.rx_byte  = b;
        @(negedge clk);
        u_if.rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (u_if.active && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", {31'h0, u_if.active}, 32'd0);
        chk("bus_drained", exp_bus.size(), 32'd0);
        chk("tx_drained", exp_tx.size(), 32'd0);
    endtask

    task automatic send_cmd(input int slow_idx);
        model_cmd();
        for (int i = 0; i < cmd_q.size(); i++) begin
            send_byte(cmd_q[i], (i == slow_idx) ? 99 : ((i == 0) ? 0 : int'($urandom_range(0, 3))));
            if (i == 0) chk("active_rise", {31'h0, u_if.active}, 32'd1);
        end
        wait_idle();
    endtask

    task automatic chk_log(input string name, input logic [31:0] b0, input int n);
        chk({name, "_len"}, tx_log.size(), n);
        for (int i = 0; i < n && i < tx_log.size(); i++)
            chk(name, {24'h0, tx_log[i]}, {24'h0, b0[8*i +: 8]});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int k_hit, t, n_before;
        logic [31:0] a, d;
        logic [7:0]  u;

        reset = 1'b1;
        u_if.rx_valid = 1'b0;
        u_if.rx_byte  = 8'h00;
        init_ref();
        repeat (3) @(negedge clk);
        chk("rst_mem_req",   {31'h0, u_if.mem_req},   32'd0);
        chk("rst_mem_we",    {31'h0, u_if.mem_we},    32'd0);
        chk("rst_mem_addr",  u_if.mem_addr,           32'd0);
        chk("rst_mem_wdata", u_if.mem_wdata,          32'd0);
        chk("rst_tx_start",  {31'h0, u_if.tx_start},  32'd0);
        chk("rst_tx_byte",   {24'h0, u_if.tx_byte},   32'd0);
        chk("rst_active",    {31'h0, u_if.active},    32'd0);
        chk("rst_err",       {31'h0, u_if.err_pulse}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Plain write
        tx_log.delete();
        mk_w(32'h0000_1000, 32'hDEAD_BEEF);
        send_cmd(-1);
        chk("w_addr", last_addr, 32'h0000_1000);
        chk("w_data", last_wdata, 32'hDEAD_BEEF);
        chk("w_we", {31'h0, last_we}, 32'd1);
        chk_log("w_ack", 32'h0000_0006, 1);

        // Read with 3 wait states, unaligned address
        mk_w(32'h0000_1010, 32'h1234_5678);
        send_cmd(-1);
        wait_mode = 3;
        tx_log.delete();
        cmd_q.delete();
        cmd_q.push_back(8'h52); cmd_q.push_back(8'h13); cmd_q.push_back(8'h10);
        cmd_q.push_back(8'h00); cmd_q.push_back(8'h00);
        send_cmd(-1);
        wait_mode = -1;
        chk("r_addr", last_addr, 32'h0000_1010);
        chk("r_we", {31'h0, last_we}, 32'd0);
        chk("r_req_len", last_req_len, 32'd4);
        chk_log("r_data", 32'h1234_5678, 4);

        // Unknown command, then a read still works
        n_before = n_req;
        tx_log.delete();
        cmd_q.delete();
        cmd_q.push_back(8'h41);
        send_cmd(-1);
        chk("nak_no_bus", n_req, n_before);
        chk_log("nak", 32'h0000_0015, 1);
        tx_log.delete();
        mk_r(32'h0000_1000);
        send_cmd(-1);
        chk_log("r_after_nak", 32'hDEAD_BEEF, 4);

        // Timeout after a partial command
        n_before = n_req;
        tx_log.delete();
        send_byte(8'h57, 0);
        chk("to_active", {31'h0, u_if.active}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        k_hit = 0;
        for (int k = 1; k <= 150 && k_hit == 0; k++) begin
            @(posedge clk);
            #1;
            if (u_if.err_pulse) k_hit = k;
        end
        exp_err++;
        chk("to_cycles", k_hit, 32'd100);
        chk("to_idle", {31'h0, u_if.active}, 32'd0);
        @(negedge clk);
        chk("to_no_bus", n_req, n_before);
        chk("to_no_tx", tx_log.size(), 32'd0);
        mk_w(32'h0000_1004, 32'h5555_AAAA);
        send_cmd(-1);

        // Byte arriving on the expiry cycle wins
        mk_w(32'h0000_2008, 32'h0F1E_2D3C);
        send_cmd(3);
        chk("late_byte_addr", last_addr, 32'h0000_2008);

        // Dropped byte while the response is being sent
        tx_log.delete();
        mk_r(32'h0000_1000);
        model_cmd();
        for (int i = 0; i < cmd_q.size(); i++) send_byte(cmd_q[i], 0);
        t = 0;
        while (!u_if.tx_start && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drop_tx_seen", {31'h0, u_if.tx_start}, 32'd1);
        send_byte(8'h57, 0);
        exp_err++;
        wait_idle();
        chk_log("drop_resp", 32'hDEAD_BEEF, 4);
        chk("drop_err_count", err_seen, exp_err);

        // Random command mix
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            d = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: mk_w(a, d);
                4, 5, 6, 7: mk_r(a);
                8: begin
                    u = 8'($urandom_range(0, 255));
                    if (u == 8'h57 || u == 8'h52) u = 8'h41;
                    cmd_q.delete();
                    cmd_q.push_back(u);
                end
                default: mk_w(a, d);
            endcase
            send_cmd(-1);
        end

        // Asynchronous reset while a request is outstanding
        wait_mode = 20;
        mk_w(32'h0000_1020, 32'hCAFE_F00D);
        model_cmd();
        for (int i = 0; i < cmd_q.size(); i++) send_byte(cmd_q[i], 0);
        t = 0;
        while (!u_if.mem_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rmid_req_seen", {31'h0, u_if.mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rmid_mem_req",  {31'h0, u_if.mem_req},   32'd0);
        chk("rmid_tx_start", {31'h0, u_if.tx_start},  32'd0);
        chk("rmid_active",   {31'h0, u_if.active},    32'd0);
        chk("rmid_err",      {31'h0, u_if.err_pulse}, 32'd0);
        exp_bus.delete();
        exp_tx.delete();
        init_ref();
        wait_mode = -1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mk_w(32'h0000_1020, 32'h0BAD_CAFE);
        send_cmd(-1);
        tx_log.delete();
        mk_r(32'h0000_1020);
        send_cmd(-1);
        chk_log("rmid_readback", 32'h0BAD_CAFE, 4);

        chk("err_total", err_seen, exp_err);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
